prbs_check: RTL and testbench
=============================

PRBS_CHECK -- requirements
Module: prbs_check

Interface
REQ-001 Parameter LN, default 8: LFSR length / polynomial degree; legal range 2..32.
REQ-002 Parameter TAPS [LN-1:0], default 8'h2d: feedback taps of the Fibonacci generator being checked.
REQ-003 Parameter LOCK_COUNT, default 16: consecutive correct predictions required to declare lock; legal range 1..255.
REQ-004 Parameter LOSS_COUNT, default 4: consecutive errors while locked that force loss of lock; legal range 1..255.
REQ-005 Port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 Port i_reset_n, input, 1: reset, asynchronous assertion, active-low.
REQ-007 Port i_ce, input, 1: qualifies i_in; one received bit per cycle with i_ce=1.
REQ-008 Port i_in, input, 1: received PRBS bit, generator output order (oldest first).
REQ-009 Port i_clear, input, 1: synchronous zeroing of o_errcnt.
REQ-010 Port o_lock, output, 1: checker synchronized to the sequence.
REQ-011 Port o_err, output, 1: one-cycle pulse per bit error detected while locked.
REQ-012 Port o_errcnt, output, 32: saturating count of errors detected while locked.

Function
REQ-013 The block SHALL hold a prediction register c[LN-1:0], updated only on i_ce=1, that shifts right with a new bit entering c[LN-1].
REQ-014 Predicted bit p SHALL be XOR-reduce(c & TAPS); error e = i_in ^ p.
REQ-015 The FSM SHALL have exactly three states: FILL, SEARCH, LOCKED.
REQ-016 FILL: each i_ce bit SHALL shift i_in into c and increment a fill counter; after the LN-th bit, next state is SEARCH with the match counter at 0; no comparison is made.
REQ-017 SEARCH: each i_ce bit SHALL shift i_in into c; if e=0 and c!=0 the match counter increments, otherwise it clears to 0.
REQ-018 SEARCH -> LOCKED SHALL occur on the edge registering the LOCK_COUNT-th consecutive match; o_lock reads 1 from that edge.
REQ-019 LOCKED: each i_ce bit SHALL shift p (not i_in) into c (flywheel), so one channel error yields exactly one counted error.
REQ-020 LOCKED: e=1 SHALL set o_err for exactly the following cycle, increment o_errcnt, and increment the loss counter; e=0 SHALL clear the loss counter.
REQ-021 LOCKED -> FILL SHALL occur on the edge registering the LOSS_COUNT-th consecutive error; o_lock drops on that edge, the fill counter clears, and that error is still counted and pulsed.
REQ-022 With i_ce=0, c, state, all counters and o_lock SHALL hold, and o_err SHALL be 0.
REQ-023 o_err and o_errcnt SHALL never change in FILL or SEARCH.
REQ-024 o_errcnt SHALL saturate at 32'hffffffff.
REQ-025 i_clear=1 SHALL zero o_errcnt on the next edge, taking priority over a simultaneous error increment; o_err still pulses.
REQ-026 All-zero input SHALL never produce lock (c==0 is never a match).

Reset
REQ-027 i_reset_n=0 SHALL immediately force state FILL, c=0, fill/match/loss counters 0, o_lock=0, o_err=0, o_errcnt=0, regardless of clock or mid-operation state.
REQ-028 After release, operation SHALL resume at the first rising edge with i_ce=1.

Verification
REQ-029 LN=8, TAPS=8'h2d, free-running seed-1 Fibonacci source, i_ce=1 continuously -> o_lock=1 after exactly 8+16=24 bits; o_errcnt=0 thereafter over 10000 bits.
REQ-030 Locked, invert one bit -> o_err high exactly one cycle, o_errcnt=1, o_lock stays 1, no further errors.
REQ-031 Locked, invert 4 consecutive bits -> o_errcnt=4, o_lock falls on the 4th error edge; clean stream relocks 24 bits later.
REQ-032 i_in held 0 for 1000 bits -> o_lock stays 0, o_errcnt stays 0.
REQ-033 Locked, i_ce toggled randomly with gaps of 0..5 cycles -> lock held, no errors; i_clear with a simultaneous error -> o_errcnt=0, o_err=1.
REQ-034 i_reset_n pulsed low mid-LOCKED between clock edges -> o_lock, o_err, o_errcnt read 0 before the next edge; relock after 24 bits.

Source files
------------

// File: rtl/prbs_check.sv
// prbs_check: self-synchronizing checker for a Fibonacci LFSR bit stream.
//   Fills a prediction register from the received stream, searches for
//   LOCK_COUNT consecutive correct predictions, then flywheels on its own
//   predictions. It counts mismatches as bit errors, and LOSS_COUNT
//   consecutive errors drop lock and restart the fill.
// Ports:
//   i_clk      clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_ce       qualifies i_in (one bit per enabled cycle)
//   i_in       received PRBS bit, oldest first
//   i_clear    synchronous clear of o_errcnt (wins over a same-cycle error)
//   o_lock     synchronized to the sequence
//   o_err      one-cycle pulse per error detected while locked
//   o_errcnt   saturating error count while locked
module prbs_check #(
    parameter int              LN         = 8,
    parameter logic [LN-1:0]   TAPS       = 8'h2d,
    parameter int              LOCK_COUNT = 16,
    parameter int              LOSS_COUNT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_ce,
    input  logic        i_in,
    input  logic        i_clear,
    output logic        o_lock,
    output logic        o_err,
    output logic [31:0] o_errcnt
);

    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;

    localparam logic [5:0] FILL_LAST = 6'(LN - 1);
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_COUNT - 1);
    localparam logic [7:0] LOSS_LAST = 8'(LOSS_COUNT - 1);

    state_t        state;
    logic [LN-1:0] c;
    logic [5:0]    fill_cnt;
    logic [7:0]    match_cnt;
    logic [7:0]    loss_cnt;
    logic          p;
    logic          e;

    // c[LN-1] is the newest bit, so the tap mask lines up with the generator.
    assign p = ^(c & TAPS);
    assign e = i_in ^ p;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state     <= FILL;
            c         <= '0;
            fill_cnt  <= '0;
            match_cnt <= '0;
            loss_cnt  <= '0;
            o_lock    <= 1'b0;
            o_err     <= 1'b0;
            o_errcnt  <= '0;
        end else begin
            o_err <= 1'b0;
            if (i_ce) begin
                case (state)
                    FILL: begin
                        c        <= {i_in, c[LN-1:1]};
                        fill_cnt <= fill_cnt + 6'd1;
                        if (fill_cnt == FILL_LAST) begin
                            state     <= SEARCH;
                            match_cnt <= '0;
                        end
                    end
                    SEARCH: begin
                        c <= {i_in, c[LN-1:1]};
                        // An all-zero register predicts zeros forever; never trust it.
                        if (!e && c != '0) begin
                            if (match_cnt == LOCK_LAST) begin
                                state     <= LOCKED;
                                o_lock    <= 1'b1;
                                match_cnt <= '0;
                                loss_cnt  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 8'd1;
                            end
                        end else begin
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Flywheel: feed back our own prediction so a channel
                        // error does not corrupt later predictions.
                        c <= {p, c[LN-1:1]};
                        if (e) begin
                            o_err <= 1'b1;
                            if (o_errcnt != '1)
                                o_errcnt <= o_errcnt + 32'd1;
                            if (loss_cnt == LOSS_LAST) begin
                                state    <= FILL;
                                o_lock   <= 1'b0;
                                fill_cnt <= '0;
                                loss_cnt <= '0;
                            end else begin
                                loss_cnt <= loss_cnt + 8'd1;
                            end
                        end else begin
                            loss_cnt <= '0;
                        end
                    end
                    default: state <= FILL;
                endcase
            end
            if (i_clear)
                o_errcnt <= '0;
        end
    end

endmodule

// File: tb/tb_prbs_check.sv
module tb_prbs_check;

    localparam int            LN         = 8;
    localparam logic [LN-1:0] TAPS       = 8'h2d;
    localparam int            LOCK_COUNT = 16;
    localparam int            LOSS_COUNT = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce    = 1'b0;
    logic        din   = 1'b0;
    logic        clr   = 1'b0;
    logic        lock;
    logic        err;
    logic [31:0] errcnt;

    always #5 clk = ~clk;

    prbs_check #(.LN(LN), .TAPS(TAPS), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_in(din), .i_clear(clr),
        .o_lock(lock), .o_err(err), .o_errcnt(errcnt)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: history of the last LN bits the checker believes in
    // (oldest first), a mode, and plain integer run-length counters.
    localparam int M_FILL = 0, M_SEARCH = 1, M_LOCKED = 2;
    bit     hist[$];
    int     m_mode, m_fill, m_match, m_loss;
    bit     m_err;
    longint m_cnt;
    logic [LN-1:0] gs;   // source generator state

    function automatic bit predict();
        bit p = 0;
        for (int i = 0; i < LN; i++)
            if (TAPS[i]) p ^= hist[i];
        return p;
    endfunction

    function automatic bit hist_nonzero();
        for (int i = 0; i < LN; i++)
            if (hist[i]) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < LN; i++) hist.push_back(1'b0);
        m_mode = M_FILL; m_fill = 0; m_match = 0; m_loss = 0;
        m_err = 0; m_cnt = 0;
        gs = 1;
    endtask

    task automatic model_step(bit c_e, bit b, bit cl);
        bit p, e;
        m_err = 0;
        if (c_e) begin
            p = predict();
            e = b ^ p;
            case (m_mode)
                M_FILL: begin
                    hist.push_back(b); void'(hist.pop_front());
                    m_fill++;
                    if (m_fill == LN) begin m_mode = M_SEARCH; m_match = 0; end
                end
                M_SEARCH: begin
                    if (!e && hist_nonzero()) m_match++; else m_match = 0;
                    hist.push_back(b); void'(hist.pop_front());
                    if (m_match == LOCK_COUNT) begin m_mode = M_LOCKED; m_loss = 0; end
                end
                default: begin
                    hist.push_back(p); void'(hist.pop_front());
                    if (e) begin
                        m_err = 1;
                        if (m_cnt < 64'hffffffff) m_cnt++;
                        m_loss++;
                        if (m_loss == LOSS_COUNT) begin m_mode = M_FILL; m_fill = 0; m_loss = 0; end
                    end else begin
                        m_loss = 0;
                    end
                end
            endcase
        end
        if (cl) m_cnt = 0;
    endtask

    task automatic gen_bit(output bit b);
        b  = gs[0];
        gs = {^(gs & TAPS), gs[LN-1:1]};
    endtask

    // One clock: drive, advance model, sample #1 after the edge.
    task automatic step(bit c_e, bit b, bit cl);
        ce = c_e; din = b; clr = cl;
        model_step(c_e, b, cl);
        @(posedge clk); #1;
        check("cyc_lock",   64'(lock),   64'(m_mode == M_LOCKED));
        check("cyc_err",    64'(err),    64'(m_err));
        check("cyc_errcnt", 64'(errcnt), 64'(m_cnt));
        ce = 0; clr = 0;
    endtask

    task automatic send_bit(bit b, bit cl, int gapmax);
        int g = (gapmax > 0) ? $urandom_range(gapmax, 0) : 0;
        for (int i = 0; i < g; i++) step(1'b0, 1'($urandom_range(1, 0)), 1'b0);
        step(1'b1, b, cl);
    endtask

    task automatic send_clean(int n);
        bit b;
        for (int i = 0; i < n; i++) begin gen_bit(b); send_bit(b, 1'b0, 0); end
    endtask

    task automatic do_reset();
        ce = 0; clr = 0;
        @(negedge clk); rst_n = 0;
        model_reset();
        @(negedge clk); rst_n = 1;
    endtask

    typedef struct {
        int nbits; int gapmax; bit zeros; int flip_at; int nflip;
        bit exp_lock; int exp_cnt;
    } scen_t;

    scen_t tbl[$];

    initial begin
        bit b;
        tbl.push_back('{24,   0, 0, -1,  0, 1, 0});
        tbl.push_back('{23,   0, 0, -1,  0, 0, 0});
        tbl.push_back('{1000, 0, 1, -1,  0, 0, 0});
        tbl.push_back('{200,  0, 0, 100, 1, 1, 1});
        tbl.push_back('{200,  0, 0, 100, 3, 1, 3});
        tbl.push_back('{110,  0, 0, 100, 4, 0, 4});
        tbl.push_back('{127,  0, 0, 100, 4, 0, 4});
        tbl.push_back('{128,  0, 0, 100, 4, 1, 4});
        tbl.push_back('{300,  5, 0, -1,  0, 1, 0});
        tbl.push_back('{300,  5, 0, 150, 2, 1, 2});

        // Reset asserted before any clock edge must clear outputs at once.
        #2 rst_n = 0;
        #1;
        check("rst_lock",   64'(lock),   64'(0));
        check("rst_err",    64'(err),    64'(0));
        check("rst_errcnt", 64'(errcnt), 64'(0));
        model_reset();
        @(negedge clk); rst_n = 1;

        foreach (tbl[k]) begin
            do_reset();
            for (int n = 0; n < tbl[k].nbits; n++) begin
                gen_bit(b);
                if (tbl[k].zeros) b = 0;
                if (n >= tbl[k].flip_at && n < tbl[k].flip_at + tbl[k].nflip) b = ~b;
                send_bit(b, 1'b0, tbl[k].gapmax);
            end
            check($sformatf("tbl%0d_lock", k), 64'(lock),   64'(tbl[k].exp_lock));
            check($sformatf("tbl%0d_cnt",  k), 64'(errcnt), 64'(tbl[k].exp_cnt));
        end

        // Long clean run after lock.
        do_reset();
        send_clean(24);
        check("long_lock0", 64'(lock), 64'(1));
        send_clean(10000);
        check("long_lock1",  64'(lock),   64'(1));
        check("long_errcnt", 64'(errcnt), 64'(0));

        // Single inverted bit: one pulse, one count, lock kept.
        gen_bit(b); send_bit(~b, 1'b0, 0);
        check("pulse_hi", 64'(err), 64'(1));
        gen_bit(b); send_bit(b, 1'b0, 0);
        check("pulse_lo",  64'(err),    64'(0));
        check("pulse_cnt", 64'(errcnt), 64'(1));
        send_clean(50);
        check("pulse_lock", 64'(lock),   64'(1));
        check("pulse_cnt2", 64'(errcnt), 64'(1));

        // Clear together with an error: count zeroed, pulse still seen.
        gen_bit(b); send_bit(~b, 1'b1, 0);
        check("clr_err", 64'(err),    64'(1));
        check("clr_cnt", 64'(errcnt), 64'(0));

        // Async reset between edges while err is high and count nonzero.
        send_clean(5);
        gen_bit(b); send_bit(~b, 1'b0, 0);
        check("pre_rst_err", 64'(err), 64'(1));
        #2 rst_n = 0;
        #1;
        check("arst_lock",   64'(lock),   64'(0));
        check("arst_err",    64'(err),    64'(0));
        check("arst_errcnt", 64'(errcnt), 64'(0));
        model_reset();
        @(negedge clk); rst_n = 1;
        send_clean(23);
        check("relock_23", 64'(lock), 64'(0));
        send_clean(1);
        check("relock_24", 64'(lock), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
